// File: rtl/core_pkg.sv
// Shared barrel-core definitions: thread-id type and the EX/MEM payload layout.
package core_pkg;

    localparam int unsigned BITS_THREADS_DEF = 3;
    typedef logic [BITS_THREADS_DEF-1:0] tid_t;

    // EX/MEM payload field offsets (LSB position) and widths, packed MSB-first as
    // reg_write, mem_write, result_src, funct3, alu_result, write_data, rd, pc_plus4.
    localparam int unsigned EM_PC_PLUS4_W   = 32;
    localparam int unsigned EM_RD_W         = 5;
    localparam int unsigned EM_WRITE_DATA_W = 32;
    localparam int unsigned EM_ALU_RESULT_W = 32;
    localparam int unsigned EM_FUNCT3_W     = 3;
    localparam int unsigned EM_RESULT_SRC_W = 2;

    localparam int unsigned EM_PC_PLUS4_LSB   = 0;
    localparam int unsigned EM_RD_LSB         = EM_PC_PLUS4_LSB + EM_PC_PLUS4_W;
    localparam int unsigned EM_WRITE_DATA_LSB = EM_RD_LSB + EM_RD_W;
    localparam int unsigned EM_ALU_RESULT_LSB = EM_WRITE_DATA_LSB + EM_WRITE_DATA_W;
    localparam int unsigned EM_FUNCT3_LSB     = EM_ALU_RESULT_LSB + EM_ALU_RESULT_W;
    localparam int unsigned EM_RESULT_SRC_LSB = EM_FUNCT3_LSB + EM_FUNCT3_W;
    localparam int unsigned EM_MEM_WRITE_LSB  = EM_RESULT_SRC_LSB + EM_RESULT_SRC_W;
    localparam int unsigned EM_REG_WRITE_LSB  = EM_MEM_WRITE_LSB + 1;

    // Upper bits above reg_write are reserved so the carried width stays 111.
    localparam int unsigned EM_PAYLOAD_W = 111;

endpackage

// File: rtl/pl_reg_elastic_if.sv
// Valid/ready beat carrying a thread id and an opaque payload.
interface pl_reg_elastic_if #(
    parameter int unsigned PAYLOAD_WIDTH = 111,
    parameter int unsigned BITS_THREADS  = 3
);
    logic                     valid;
    logic                     ready;
    logic [BITS_THREADS-1:0]  tid;
    logic [PAYLOAD_WIDTH-1:0] payload;

    modport master (output valid, output tid, output payload, input ready);
    modport slave  (input valid, input tid, input payload, output ready);
endinterface

// File: rtl/pl_slot.sv
// One storage slot: valid bit plus tid/payload, with load and clear.
module pl_slot #(
    parameter int unsigned PAYLOAD_WIDTH = 111,
    parameter int unsigned BITS_THREADS  = 3,
    parameter bit          CLEAR_PAYLOAD = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_i,
    input  logic                     clr_i,
    input  logic [BITS_THREADS-1:0]  tid_i,
    input  logic [PAYLOAD_WIDTH-1:0] payload_i,
    output logic                     valid_o,
    output logic [BITS_THREADS-1:0]  tid_o,
    output logic [PAYLOAD_WIDTH-1:0] payload_o
);
    logic                     valid_q;
    logic [BITS_THREADS-1:0]  tid_q;
    logic [PAYLOAD_WIDTH-1:0] payload_q;

    // Valid bit: reset > load > clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end
    end

    // Data: zeroed on reset/clear only when CLEAR_PAYLOAD, otherwise left stale.
    always_ff @(posedge clk) begin
        if (rst_n && load_i) begin
            tid_q     <= tid_i;
            payload_q <= payload_i;
        end else if (CLEAR_PAYLOAD && (!rst_n || clr_i)) begin
            tid_q     <= '0;
            payload_q <= '0;
        end
    end

    assign valid_o   = valid_q;
    assign tid_o     = tid_q;
    assign payload_o = payload_q;
endmodule

// File: rtl/pl_reg_elastic.sv
// Elastic two-slot pipeline register with global flush and per-thread kill.
// in_ready is purely registered (!skid_valid), so no combinational path from out_ready.
module pl_reg_elastic
    import core_pkg::*;
#(
    parameter int unsigned PAYLOAD_WIDTH = EM_PAYLOAD_W,
    parameter int unsigned BITS_THREADS  = BITS_THREADS_DEF,
    parameter bit          CLEAR_PAYLOAD = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    kill_en_i,
    input  logic [BITS_THREADS-1:0] kill_tid_i,
    pl_reg_elastic_if.slave         in_if,
    pl_reg_elastic_if.master        out_if,
    output logic [1:0]              occupancy_o
);
    logic                     head_v, skid_v;
    logic [BITS_THREADS-1:0]  head_tid, skid_tid, head_ld_tid;
    logic [PAYLOAD_WIDTH-1:0] head_pl, skid_pl, head_ld_pl;
    logic head_ld, head_clr, head_from_skid, skid_ld, skid_clr;
    logic head_nv, skid_nv;
    logic push, pop, head_live, skid_live, new_beat;
    logic [1:0] occ_d, occ_q;

    assign in_if.ready = !skid_v;
    assign push        = in_if.valid && !skid_v;
    assign pop         = head_v && out_if.ready;

    // A popped head was already seen downstream, so kill does not apply to it.
    assign head_live = head_v && !pop &&
                       !(kill_en_i && (head_tid == kill_tid_i));
    assign skid_live = skid_v && !(kill_en_i && (skid_tid == kill_tid_i));
    assign new_beat  = push && !(kill_en_i && (in_if.tid == kill_tid_i));

    // Next-state: survivors compact in age order head -> skid -> incoming.
    always_comb begin
        head_ld        = 1'b0;
        head_clr       = 1'b0;
        head_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        head_nv        = head_v;
        skid_nv        = skid_v;
        if (flush_i) begin
            head_clr = 1'b1;
            skid_clr = 1'b1;
            head_nv  = 1'b0;
            skid_nv  = 1'b0;
        end else if (head_live) begin
            head_nv = 1'b1;
            if (skid_live) begin
                skid_nv = 1'b1;
            end else if (new_beat) begin
                skid_ld = 1'b1;
                skid_nv = 1'b1;
            end else begin
                skid_clr = 1'b1;
                skid_nv  = 1'b0;
            end
        end else if (skid_live) begin
            head_ld        = 1'b1;
            head_from_skid = 1'b1;
            head_nv        = 1'b1;
            if (new_beat) begin
                skid_ld = 1'b1;
                skid_nv = 1'b1;
            end else begin
                skid_clr = 1'b1;
                skid_nv  = 1'b0;
            end
        end else if (new_beat) begin
            head_ld  = 1'b1;
            head_nv  = 1'b1;
            skid_clr = 1'b1;
            skid_nv  = 1'b0;
        end else begin
            head_clr = 1'b1;
            skid_clr = 1'b1;
            head_nv  = 1'b0;
            skid_nv  = 1'b0;
        end
    end

    assign head_ld_tid = head_from_skid ? skid_tid : in_if.tid;
    assign head_ld_pl  = head_from_skid ? skid_pl  : in_if.payload;
    assign occ_d       = {1'b0, head_nv} + {1'b0, skid_nv};

    // Occupancy tracks the slot valid bits, registered on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    pl_slot #(
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
        .BITS_THREADS  (BITS_THREADS),
        .CLEAR_PAYLOAD (CLEAR_PAYLOAD)
    ) u_head (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (head_ld),
        .clr_i     (head_clr),
        .tid_i     (head_ld_tid),
        .payload_i (head_ld_pl),
        .valid_o   (head_v),
        .tid_o     (head_tid),
        .payload_o (head_pl)
    );

    pl_slot #(
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
        .BITS_THREADS  (BITS_THREADS),
        .CLEAR_PAYLOAD (CLEAR_PAYLOAD)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (skid_ld),
        .clr_i     (skid_clr),
        .tid_i     (in_if.tid),
        .payload_i (in_if.payload),
        .valid_o   (skid_v),
        .tid_o     (skid_tid),
        .payload_o (skid_pl)
    );

    assign out_if.valid   = head_v;
    assign out_if.tid     = head_tid;
    assign out_if.payload = head_pl;
    assign occupancy_o    = occ_q;
endmodule

// File: tb/tb_pl_reg_elastic.sv
// Directed and small random checks of pl_reg_elastic against hand values and a queue model.
module tb_pl_reg_elastic;
    localparam int unsigned PW = 111;
    localparam int unsigned TW = 3;

    typedef struct packed {
        logic [TW-1:0] tid;
        logic [PW-1:0] pl;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          kill_en;
    logic [TW-1:0] kill_tid;
    logic [1:0]    occupancy;

    int n_cmp;
    int n_fail;

    pl_reg_elastic_if #(.PAYLOAD_WIDTH(PW), .BITS_THREADS(TW)) in_if ();
    pl_reg_elastic_if #(.PAYLOAD_WIDTH(PW), .BITS_THREADS(TW)) out_if ();

    pl_reg_elastic #(
        .PAYLOAD_WIDTH (PW),
        .BITS_THREADS  (TW),
        .CLEAR_PAYLOAD (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .kill_en_i   (kill_en),
        .kill_tid_i  (kill_tid),
        .in_if       (in_if.slave),
        .out_if      (out_if.master),
        .occupancy_o (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are registered so #1 after the edge is stable.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [TW-1:0] t, input logic [PW-1:0] p);
        in_if.valid   = v;
        in_if.tid     = t;
        in_if.payload = p;
    endtask

    initial begin
        beat_t q[$];
        beat_t nq[$];
        beat_t b;
        logic  do_push, do_pop, do_kill;
        logic [TW-1:0] ktid;

        n_cmp  = 0;
        n_fail = 0;
        rst_n = 1'b0; flush = 1'b0; kill_en = 1'b0; kill_tid = '0;
        out_if.ready = 1'b0;
        drive_in(1'b0, '0, '0);

        // Reset
        cyc(); cyc();
        chk("rst_out_valid", out_if.valid, 0);
        chk("rst_in_ready", in_if.ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_payload", out_if.payload, 0);
        chk("rst_tid", out_if.tid, 0);
        rst_n = 1'b1;

        // Back-pressure
        drive_in(1'b1, 3'd1, 111'hA);
        cyc();
        chk("bp_occ1", occupancy, 1);
        chk("bp_ready1", in_if.ready, 1);
        drive_in(1'b1, 3'd2, 111'hB);
        cyc();
        chk("bp_occ2", occupancy, 2);
        chk("bp_ready0", in_if.ready, 0);
        chk("bp_head_a", out_if.payload, 111'hA);
        chk("bp_head_tid1", out_if.tid, 1);
        drive_in(1'b0, '0, '0);
        out_if.ready = 1'b1;
        cyc();
        chk("bp_head_b", out_if.payload, 111'hB);
        chk("bp_head_tid2", out_if.tid, 2);
        chk("bp_ready_after_pop", in_if.ready, 1);
        chk("bp_occ_after_pop", occupancy, 1);
        cyc();
        chk("bp_empty_valid", out_if.valid, 0);
        chk("bp_empty_occ", occupancy, 0);

        // Streaming
        for (int i = 0; i < 8; i++) begin
            drive_in(1'b1, TW'(i), PW'(i));
            cyc();
            chk("st_valid", out_if.valid, 1);
            chk("st_payload", out_if.payload, i);
            chk("st_occ", occupancy, 1);
        end
        drive_in(1'b0, '0, '0);
        cyc();
        chk("st_drain_occ", occupancy, 0);

        // Kill
        out_if.ready = 1'b0;
        drive_in(1'b1, 3'd3, 111'h11);
        cyc();
        drive_in(1'b1, 3'd5, 111'h22);
        cyc();
        chk("kl_occ2", occupancy, 2);
        drive_in(1'b1, 3'd3, 111'h33);
        kill_en = 1'b1; kill_tid = 3'd3;
        cyc();
        chk("kl_head_tid", out_if.tid, 5);
        chk("kl_head_pl", out_if.payload, 111'h22);
        chk("kl_occ1", occupancy, 1);
        // Incoming tid3 beat accepted but dropped
        chk("kl_ready", in_if.ready, 1);
        drive_in(1'b1, 3'd3, 111'h44);
        cyc();
        chk("kl_in_drop_occ", occupancy, 1);
        chk("kl_in_drop_head", out_if.payload, 111'h22);
        // Popped head matching kill_tid still leaves
        drive_in(1'b0, '0, '0);
        kill_tid = 3'd5;
        out_if.ready = 1'b1;
        cyc();
        chk("kl_pop_occ", occupancy, 0);
        chk("kl_pop_valid", out_if.valid, 0);
        kill_en = 1'b0;

        // Flush vs push
        out_if.ready = 1'b0;
        drive_in(1'b1, 3'd0, 111'h55);
        cyc();
        drive_in(1'b1, 3'd1, 111'h66);
        cyc();
        chk("fl_occ2", occupancy, 2);
        drive_in(1'b1, 3'd2, 111'h77);
        flush = 1'b1;
        out_if.ready = 1'b1;
        cyc();
        chk("fl_occ", occupancy, 0);
        chk("fl_valid", out_if.valid, 0);
        chk("fl_ready", in_if.ready, 1);
        chk("fl_payload", out_if.payload, 0);
        flush = 1'b0;
        drive_in(1'b0, '0, '0);
        cyc();
        chk("fl_lost", occupancy, 0);

        // Random against a queue model
        q.delete();
        for (int c = 0; c < 300; c++) begin
            b.tid = TW'($urandom_range(0, 7));
            b.pl  = {$urandom, $urandom, $urandom, $urandom};
            drive_in(1'($urandom_range(0, 1)), b.tid, b.pl);
            out_if.ready = 1'($urandom_range(0, 1));
            do_kill = ($urandom_range(0, 7) == 0);
            ktid = TW'($urandom_range(0, 7));
            kill_en = do_kill;
            kill_tid = ktid;
            do_push = in_if.valid && (q.size() < 2);
            do_pop  = (q.size() > 0) && out_if.ready;
            if (do_pop) void'(q.pop_front());
            if (do_kill) begin
                nq.delete();
                foreach (q[k]) if (q[k].tid != ktid) nq.push_back(q[k]);
                q = nq;
            end
            if (do_push && !(do_kill && b.tid == ktid)) q.push_back(b);
            cyc();
            chk("rn_occ", occupancy, q.size());
            chk("rn_valid", out_if.valid, q.size() > 0);
            chk("rn_ready", in_if.ready, q.size() < 2);
            if (q.size() > 0) begin
                chk("rn_tid", out_if.tid, q[0].tid);
                chk("rn_payload", out_if.payload, q[0].pl);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
